// File: rtl/axi_write_master.sv
// axi_write_master: master-side AXI write port in front of the interconnect's
// write arbiter. Requests get a round-robin ID, issue AW, then stream W beats
// and collect B in address order through an {id, len} order queue.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   A_IDLE   | ready to accept a client request if the next ID slot is free
//   A_ISSUE  | AW_valid asserted, waiting for the arbiter's address grant
//   W_IDLE   | no data phase active; B_ready low so the arbiter can rotate
//   W_REQ    | B_ready asserted for the queue head, waiting for W_grant
//   W_DATA   | beats passed through from client to slave, counted to len
//   W_RESP   | waiting for B_valid; completion frees the ID and pops queue

module axi_write_master #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int NUM_OUTSTANDING_TRANS = 2,
    parameter int LEN_WIDTH             = 4
) (
    input  logic                                     clk,
    input  logic                                     clr,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [ADDR_WIDTH-1:0]                    req_addr,
    input  logic [LEN_WIDTH-1:0]                     req_len,
    input  logic                                     wd_valid,
    output logic                                     wd_ready,
    input  logic [DATA_WIDTH-1:0]                    wd_data,
    output logic                                     resp_valid,
    output logic [$clog2(NUM_OUTSTANDING_TRANS)-1:0] resp_id,
    output logic                                     resp_err,
    output logic                                     AW_valid,
    output logic [ADDR_WIDTH-1:0]                    AW_addr,
    output logic [$clog2(NUM_OUTSTANDING_TRANS)-1:0] AW_id,
    input  logic                                     AW_grant,
    output logic                                     B_ready,
    output logic [$clog2(NUM_OUTSTANDING_TRANS)-1:0] W_id,
    input  logic                                     W_grant,
    output logic                                     W_valid,
    output logic [DATA_WIDTH-1:0]                    W_data,
    output logic                                     W_last,
    input  logic                                     W_ready,
    input  logic                                     B_valid,
    input  logic [1:0]                               B_resp
);

    localparam int IDW  = $clog2(NUM_OUTSTANDING_TRANS);
    localparam int CNTW = IDW + 1;

    typedef enum logic {A_IDLE, A_ISSUE} a_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA, W_RESP} w_state_t;

    a_state_t                          a_state;
    w_state_t                          w_state;
    logic [NUM_OUTSTANDING_TRANS-1:0]  busy;
    logic [NUM_OUTSTANDING_TRANS-1:0]  busy_nxt;
    logic [IDW-1:0]                    next_id;
    logic [ADDR_WIDTH-1:0]             aw_addr_q;
    logic [IDW-1:0]                    aw_id_q;
    logic [LEN_WIDTH-1:0]              aw_len_q;

    logic [IDW-1:0]                    q_id  [NUM_OUTSTANDING_TRANS];
    logic [LEN_WIDTH-1:0]              q_len [NUM_OUTSTANDING_TRANS];
    logic [IDW-1:0]                    wr_ptr;
    logic [IDW-1:0]                    rd_ptr;
    logic [CNTW-1:0]                   q_count;

    logic [LEN_WIDTH-1:0]              beat_cnt;
    logic                              req_fire;
    logic                              aw_fire;
    logic                              b_fire;
    logic                              in_data;
    logic [IDW-1:0]                    head_id;
    logic [LEN_WIDTH-1:0]              head_len;

    assign head_id  = q_id[rd_ptr];
    assign head_len = q_len[rd_ptr];
    assign in_data  = (w_state == W_DATA);

    // req_ready is forced low while clr is held so nothing is accepted in reset
    assign req_ready = !clr && (a_state == A_IDLE) && !busy[next_id];
    assign req_fire  = req_valid && req_ready;
    assign AW_valid  = (a_state == A_ISSUE);
    assign AW_addr   = aw_addr_q;
    assign AW_id     = aw_id_q;
    assign aw_fire   = AW_valid && AW_grant;

    assign B_ready   = (w_state != W_IDLE);
    assign W_id      = B_ready ? head_id : '0;
    assign W_valid   = in_data && wd_valid;
    assign W_data    = in_data ? wd_data : '0;
    assign wd_ready  = in_data && W_ready;
    assign W_last    = in_data && (beat_cnt == head_len);
    assign b_fire    = (w_state == W_RESP) && B_valid;

    // ID slot bookkeeping: a completing ID is freed while a new one may be taken
    always_comb begin
        busy_nxt = busy;
        if (b_fire) begin
            busy_nxt[head_id] = 1'b0;
        end
        if (req_fire) begin
            busy_nxt[next_id] = 1'b1;
        end
    end

    // Address FSM: accept, allocate ID, hold AW until the arbiter grants it
    always_ff @(posedge clk) begin
        if (clr) begin
            a_state   <= A_IDLE;
            busy      <= '0;
            next_id   <= '0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_len_q  <= '0;
        end else begin
            busy <= busy_nxt;
            case (a_state)
                A_IDLE: begin
                    if (req_fire) begin
                        a_state   <= A_ISSUE;
                        aw_addr_q <= req_addr;
                        aw_len_q  <= req_len;
                        aw_id_q   <= next_id;
                        next_id   <= next_id + IDW'(1);
                    end
                end
                A_ISSUE: begin
                    if (AW_grant) begin
                        a_state <= A_IDLE;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    // Order queue: pushed when the address is granted, popped on B completion
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (aw_fire) begin
                q_id[wr_ptr]  <= aw_id_q;
                q_len[wr_ptr] <= aw_len_q;
                wr_ptr        <= wr_ptr + IDW'(1);
            end
            if (b_fire) begin
                rd_ptr <= rd_ptr + IDW'(1);
            end
            case ({aw_fire, b_fire})
                2'b10:   q_count <= q_count + CNTW'(1);
                2'b01:   q_count <= q_count - CNTW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Data/response FSM: serves the queue head, counts beats, registers B result
    always_ff @(posedge clk) begin
        if (clr) begin
            w_state    <= W_IDLE;
            beat_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (q_count != '0) begin
                        w_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (W_grant) begin
                        w_state  <= W_DATA;
                        beat_cnt <= '0;
                    end
                end
                W_DATA: begin
                    if (W_valid && W_ready) begin
                        if (W_last) begin
                            w_state <= W_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (B_valid) begin
                        w_state    <= W_IDLE;
                        resp_valid <= 1'b1;
                        resp_id    <= head_id;
                        resp_err   <= |B_resp;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Directed bench for axi_write_master with 2 ID slots and 4-bit burst length.
module tb_axi_write_master;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        resp_valid;
    logic [0:0]  resp_id;
    logic        resp_err;
    logic        AW_valid;
    logic [31:0] AW_addr;
    logic [0:0]  AW_id;
    logic        AW_grant;
    logic        B_ready;
    logic [0:0]  W_id;
    logic        W_grant;
    logic        W_valid;
    logic [31:0] W_data;
    logic        W_last;
    logic        W_ready;
    logic        B_valid;
    logic [1:0]  B_resp;

    int passed = 0;
    int total  = 0;

    axi_write_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_OUTSTANDING_TRANS(2), .LEN_WIDTH(4)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
        .AW_valid(AW_valid), .AW_addr(AW_addr), .AW_id(AW_id), .AW_grant(AW_grant),
        .B_ready(B_ready), .W_id(W_id), .W_grant(W_grant),
        .W_valid(W_valid), .W_data(W_data), .W_last(W_last), .W_ready(W_ready),
        .B_valid(B_valid), .B_resp(B_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; req_len = '0;
        wd_valid = 0; wd_data = '0;
        AW_grant = 0; W_grant = 0; W_ready = 0;
        B_valid = 0; B_resp = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1;
        tick();
        tick();
        clr = 0;
        #1;
    endtask

    task automatic issue_req(input logic [31:0] addr, input logic [3:0] len);
        int n;
        req_valid = 1; req_addr = addr; req_len = len;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (req_ready !== 1'b1) $display("FAIL issue_req_ready: req_ready=%b want 1", req_ready);
        else passed++;
        tick();
        req_valid = 0;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
    endtask

    task automatic serve_txn(input int nbeats, input logic [1:0] resp);
        int n;
        n = 0;
        while (B_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (B_ready !== 1'b1) $display("FAIL serve_b_ready_wait: B_ready=%b want 1", B_ready);
        else passed++;
        W_grant = 1;
        tick();
        W_grant = 0;
        wd_valid = 1; W_ready = 1;
        for (int i = 0; i < nbeats; i++) begin
            wd_data = 32'hD000_0000 + i;
            tick();
        end
        wd_valid = 0; W_ready = 0;
        B_valid = 1; B_resp = resp;
        tick();
        B_valid = 0; B_resp = 2'b00;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1;
        tick();
        tick();
        #1;
        total++;
        if ({req_ready, AW_valid, B_ready, W_valid, W_last, wd_ready, resp_valid, resp_err} !== 8'h00)
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {req_ready, AW_valid, B_ready, W_valid, W_last, wd_ready, resp_valid, resp_err});
        else passed++;
        total++;
        if ({AW_addr, AW_id, W_id, resp_id} !== 35'h0)
            $display("FAIL reset_ids: AW_addr=%h AW_id=%b W_id=%b resp_id=%b want 0",
                     AW_addr, AW_id, W_id, resp_id);
        else passed++;
        clr = 0;
        #1;
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: req_ready=%b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 1; req_addr = 32'h0001_0000; req_len = 4'd3;
        #1;
        total++;
        if (req_ready !== 1'b1) $display("FAIL single_req_ready: got %b want 1", req_ready);
        else passed++;
        tick();
        req_valid = 0;
        #1;
        total++;
        if ({AW_valid, AW_addr, AW_id} !== {1'b1, 32'h0001_0000, 1'b0})
            $display("FAIL single_aw: valid=%b addr=%h id=%b want 1 00010000 0", AW_valid, AW_addr, AW_id);
        else passed++;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        total++;
        if ({AW_valid, B_ready} !== 2'b00)
            $display("FAIL single_g1: AW_valid=%b B_ready=%b want 0 0", AW_valid, B_ready);
        else passed++;
        tick();
        total++;
        if ({B_ready, W_id, W_valid} !== 3'b100)
            $display("FAIL single_g2: B_ready=%b W_id=%b W_valid=%b want 1 0 0", B_ready, W_id, W_valid);
        else passed++;
        W_grant = 1;
        tick();
        W_grant = 0;
        for (int i = 0; i < 4; i++) begin
            wd_valid = 1; W_ready = 1; wd_data = 32'hA0 + i;
            #1;
            total++;
            if ({W_valid, wd_ready, W_last} !== {1'b1, 1'b1, (i == 3)} || W_data !== 32'hA0 + i)
                $display("FAIL single_beat%0d: valid=%b ready=%b last=%b data=%h want 1 1 %b %h",
                         i, W_valid, wd_ready, W_last, W_data, (i == 3), 32'hA0 + i);
            else passed++;
            tick();
        end
        wd_valid = 0; W_ready = 0;
        #1;
        total++;
        if ({B_ready, W_valid, resp_valid} !== 3'b100)
            $display("FAIL single_wresp: B_ready=%b W_valid=%b resp_valid=%b want 1 0 0",
                     B_ready, W_valid, resp_valid);
        else passed++;
        B_valid = 1; B_resp = 2'b00;
        tick();
        B_valid = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_err, B_ready} !== 4'b1000)
            $display("FAIL single_resp: valid=%b id=%b err=%b B_ready=%b want 1 0 0 0",
                     resp_valid, resp_id, resp_err, B_ready);
        else passed++;
        tick();
        total++;
        if (resp_valid !== 1'b0) $display("FAIL single_resp_pulse: resp_valid=%b want 0", resp_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1; req_addr = 32'h100; req_len = 4'd0;
        #1;
        tick();
        req_addr = 32'h200;
        #1;
        total++;
        if (AW_id !== 1'b0) $display("FAIL b2b_aw_id0: got %b want 0", AW_id);
        else passed++;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        tick();
        req_addr = 32'h300;
        #1;
        total++;
        if ({AW_id, AW_addr} !== {1'b1, 32'h200})
            $display("FAIL b2b_aw_id1: id=%b addr=%h want 1 00000200", AW_id, AW_addr);
        else passed++;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        total++;
        if (req_ready !== 1'b0) $display("FAIL b2b_third_stalled: req_ready=%b want 0", req_ready);
        else passed++;
        W_grant = 1;
        tick();
        W_grant = 0;
        wd_valid = 1; W_ready = 1;
        #1;
        tick();
        wd_valid = 0; W_ready = 0; B_valid = 1;
        #1;
        total++;
        if (req_ready !== 1'b0) $display("FAIL b2b_stalled_in_resp: req_ready=%b want 0", req_ready);
        else passed++;
        tick();
        B_valid = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, req_ready} !== 3'b101)
            $display("FAIL b2b_freed_slot: resp_valid=%b resp_id=%b req_ready=%b want 1 0 1",
                     resp_valid, resp_id, req_ready);
        else passed++;
        tick();
        req_valid = 0;
        #1;
        total++;
        if ({AW_valid, AW_id, AW_addr} !== {1'b1, 1'b0, 32'h300})
            $display("FAIL b2b_third_id: valid=%b id=%b addr=%h want 1 0 00000300", AW_valid, AW_id, AW_addr);
        else passed++;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        serve_txn(1, 2'b00);
        total++;
        if ({resp_valid, resp_id} !== 2'b11)
            $display("FAIL b2b_resp_second: valid=%b id=%b want 1 1", resp_valid, resp_id);
        else passed++;
        serve_txn(1, 2'b00);
        total++;
        if ({resp_valid, resp_id} !== 2'b10)
            $display("FAIL b2b_resp_third: valid=%b id=%b want 1 0", resp_valid, resp_id);
        else passed++;
    endtask

    task automatic test_backpressure();
        int beats, cyc, mirror_err, last_err, data_err, lasts, n;
        do_reset();
        issue_req(32'h900, 4'd7);
        n = 0;
        while (B_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        W_grant = 1;
        tick();
        W_grant = 0;
        beats = 0; cyc = 0; mirror_err = 0; last_err = 0; data_err = 0; lasts = 0;
        wd_valid = 1;
        while (beats < 8 && cyc < 40) begin
            W_ready = (cyc % 2 == 1);
            wd_data = 32'hB000 + beats;
            #1;
            if (wd_ready !== W_ready || W_valid !== 1'b1) mirror_err++;
            if (W_data !== wd_data) data_err++;
            if (W_last !== (beats == 7)) last_err++;
            if (W_ready && W_valid) begin
                if (W_last) lasts++;
                beats++;
            end
            tick();
            cyc++;
        end
        wd_valid = 0; W_ready = 1;
        #1;
        total++;
        if (beats !== 8) $display("FAIL bp_beats: got %0d want 8", beats);
        else passed++;
        total++;
        if (mirror_err !== 0 || data_err !== 0)
            $display("FAIL bp_mirror: ready/valid errors=%0d data errors=%0d want 0 0", mirror_err, data_err);
        else passed++;
        total++;
        if (last_err !== 0 || lasts !== 1)
            $display("FAIL bp_last: errors=%0d last beats=%0d want 0 1", last_err, lasts);
        else passed++;
        total++;
        if ({B_ready, wd_ready, W_last} !== 3'b100)
            $display("FAIL bp_in_resp: B_ready=%b wd_ready=%b W_last=%b want 1 0 0", B_ready, wd_ready, W_last);
        else passed++;
        W_ready = 0; B_valid = 1;
        tick();
        B_valid = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_err} !== 3'b100)
            $display("FAIL bp_resp: valid=%b id=%b err=%b want 1 0 0", resp_valid, resp_id, resp_err);
        else passed++;
    endtask

    task automatic test_err_ignore();
        int n;
        do_reset();
        issue_req(32'h700, 4'd1);
        n = 0;
        while (B_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        W_grant = 1;
        tick();
        W_grant = 0;
        wd_valid = 1; W_ready = 0; B_valid = 1; B_resp = 2'b10;
        tick();
        B_valid = 0; B_resp = 2'b00;
        #1;
        total++;
        if ({resp_valid, W_valid, W_last} !== 3'b010)
            $display("FAIL ignore_b_in_data: resp_valid=%b W_valid=%b W_last=%b want 0 1 0",
                     resp_valid, W_valid, W_last);
        else passed++;
        W_ready = 1;
        tick();
        total++;
        if (W_last !== 1'b1) $display("FAIL err_beat2_last: W_last=%b want 1", W_last);
        else passed++;
        tick();
        wd_valid = 0; W_ready = 0;
        B_valid = 1; B_resp = 2'b10;
        tick();
        B_valid = 0; B_resp = 2'b00;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_err} !== 3'b101)
            $display("FAIL err_resp: valid=%b id=%b err=%b want 1 0 1", resp_valid, resp_id, resp_err);
        else passed++;
    endtask

    task automatic test_clr_mid();
        int n, bad;
        do_reset();
        issue_req(32'h500, 4'd3);
        n = 0;
        while (B_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        W_grant = 1;
        tick();
        W_grant = 0;
        wd_valid = 1; W_ready = 1; wd_data = 32'h1;
        tick();
        wd_data = 32'h2;
        clr = 1;
        tick();
        clr = 0;
        #1;
        total++;
        if ({W_valid, wd_ready, B_ready, W_id, W_last, AW_valid, resp_valid} !== 7'b0 || W_data !== 32'h0)
            $display("FAIL clr_outputs: W_valid=%b wd_ready=%b B_ready=%b W_id=%b W_last=%b AW_valid=%b resp_valid=%b W_data=%h want all 0",
                     W_valid, wd_ready, B_ready, W_id, W_last, AW_valid, resp_valid, W_data);
        else passed++;
        wd_valid = 0; W_ready = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0 || B_ready !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL clr_no_resp: bad cycles=%0d want 0", bad);
        else passed++;
        req_valid = 1; req_addr = 32'h600; req_len = 4'd0;
        #1;
        tick();
        req_valid = 0;
        #1;
        total++;
        if ({AW_valid, AW_id} !== 2'b10) $display("FAIL clr_next_id: AW_valid=%b AW_id=%b want 1 0", AW_valid, AW_id);
        else passed++;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        serve_txn(1, 2'b00);
        total++;
        if ({resp_valid, resp_id} !== 2'b10)
            $display("FAIL clr_after_resp: valid=%b id=%b want 1 0", resp_valid, resp_id);
        else passed++;
    endtask

    task automatic test_len0_b2b();
        do_reset();
        req_valid = 1; req_addr = 32'h40; req_len = 4'd0;
        #1;
        tick();
        req_addr = 32'h80;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        #1;
        tick();
        req_valid = 0;
        #1;
        total++;
        if ({B_ready, W_id, AW_valid, AW_id} !== 4'b1011)
            $display("FAIL len0_setup: B_ready=%b W_id=%b AW_valid=%b AW_id=%b want 1 0 1 1",
                     B_ready, W_id, AW_valid, AW_id);
        else passed++;
        AW_grant = 1; W_grant = 1;
        tick();
        AW_grant = 0; W_grant = 0;
        wd_valid = 1; W_ready = 1; wd_data = 32'h55;
        #1;
        total++;
        if ({W_valid, W_last} !== 2'b11) $display("FAIL len0_last: W_valid=%b W_last=%b want 1 1", W_valid, W_last);
        else passed++;
        tick();
        wd_valid = 0; W_ready = 0; B_valid = 1;
        tick();
        B_valid = 0;
        #1;
        total++;
        if ({resp_valid, resp_id, B_ready} !== 3'b100)
            $display("FAIL len0_gap: resp_valid=%b resp_id=%b B_ready=%b want 1 0 0", resp_valid, resp_id, B_ready);
        else passed++;
        tick();
        total++;
        if ({B_ready, W_id} !== 2'b11) $display("FAIL len0_second_req: B_ready=%b W_id=%b want 1 1", B_ready, W_id);
        else passed++;
        serve_txn(1, 2'b01);
        total++;
        if ({resp_valid, resp_id, resp_err} !== 3'b111)
            $display("FAIL len0_second_resp: valid=%b id=%b err=%b want 1 1 1", resp_valid, resp_id, resp_err);
        else passed++;
    endtask

    initial begin
        clr = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_err_ignore();
        test_clr_mid();
        test_len0_b2b();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
